// File: rtl/key_det_pkg.sv
// Shared state encodings and sizing helper for the multi-key debouncer.
package key_det_pkg;

    typedef logic [3:0] state_t;

    localparam state_t IDLE    = 4'b0001;
    localparam state_t FILTER0 = 4'b0010;
    localparam state_t DOWN    = 4'b0100;
    localparam state_t FILTER1 = 4'b1000;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/key_det_chan.sv
// One key channel: 2-FF sync, edge detect, shared debounce/long-press counter, 4-state FSM.
// Events are DEB_CYCLES+3 clocks after a stable level; outputs are registered and there is no backpressure.
module key_det_chan
    import key_det_pkg::*;
#(
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_p,
    output logic key_pressed,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CW = cnt_width(LONG_CYCLES);
    localparam logic [CW-1:0] DEB_MAX  = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES - 1);

    logic          s1_q, s1_d, s2_q, s2_d;
    logic          seen_q, seen_d, armed_q, armed_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cnt_en_q, cnt_en_d;
    logic          long_done_q, long_done_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;

    logic rise, fall, deb_full, long_full;

    always_comb begin
        rise = s1_q & ~s2_q;
        fall = ~s1_q & s2_q;
        // Qualifying with cnt_en_q hides the stale count left over on the cycle a state is entered.
        deb_full  = cnt_en_q && (cnt_q == DEB_MAX);
        long_full = cnt_en_q && (cnt_q == LONG_MAX);

        s1_d   = key_p;
        s2_d   = s1_q;
        seen_d = 1'b1;
        // A key already held through reset must be seen released before it can be accepted.
        armed_d = armed_q | (seen_q & ~s1_q);

        cnt_d = '0;
        if (cnt_en_q) begin
            cnt_d = (cnt_q == LONG_MAX) ? cnt_q : cnt_q + CW'(1);
        end

        state_d     = state_q;
        cnt_en_d    = cnt_en_q;
        long_done_d = long_done_q;
        pressed_d   = pressed_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_en_d    = 1'b0;
                pressed_d   = 1'b0;
                long_done_d = 1'b0;
                if (rise && armed_q) begin
                    state_d = FILTER0;
                end
            end
            FILTER0: begin
                if (deb_full && s2_q) begin
                    state_d   = DOWN;
                    cnt_en_d  = 1'b0;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                end else if (fall || deb_full) begin
                    state_d  = IDLE;
                    cnt_en_d = 1'b0;
                end else begin
                    cnt_en_d = 1'b1;
                end
            end
            DOWN: begin
                if (long_full && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (fall) begin
                    state_d  = FILTER1;
                    cnt_en_d = 1'b0;
                end else begin
                    cnt_en_d = 1'b1;
                end
            end
            FILTER1: begin
                if (deb_full && !s2_q) begin
                    state_d     = IDLE;
                    cnt_en_d    = 1'b0;
                    pressed_d   = 1'b0;
                    release_d   = 1'b1;
                    long_done_d = 1'b0;
                end else if (rise || deb_full) begin
                    state_d  = DOWN;
                    cnt_en_d = 1'b0;
                end else begin
                    cnt_en_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_en_d    = 1'b0;
                pressed_d   = 1'b0;
                long_done_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            seen_q      <= 1'b0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cnt_en_q    <= 1'b0;
            long_done_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            seen_q      <= seen_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cnt_en_q    <= cnt_en_d;
            long_done_q <= long_done_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign key_pressed = pressed_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;

endmodule

// File: rtl/key_det_multi.sv
// Bank of N_KEYS independent debounced key channels with press/release/long-press pulses.
// Latency DEB_CYCLES+3 clocks from a stable pin level to its event; no backpressure, pulses are one cycle.
module key_det_multi
    import key_det_pkg::*;
#(
    parameter int N_KEYS      = 4,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int LONG_CYCLES = 50_000_000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key,
    output logic [N_KEYS-1:0] key_pressed,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long
);

    logic [N_KEYS-1:0] key_p;

    assign key_p = key ^ {N_KEYS{ACTIVE_LOW}};

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_det_chan #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .key_p       (key_p[i]),
            .key_pressed (key_pressed[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule
